// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer
//   Multi-cycle WIDTH-bit adder built around a single 4-bit carry-lookahead
//   slice. One operand pair is latched per transaction and then fed through
//   the slice one nibble per cycle, LSB first. The inter-nibble carry is held
//   in a register. The assembled result is presented with a valid/ready
//   handshake.
//
//   Optional feature, selected at compile time with macro CLA_SEQ_SUB_EN:
//     defined   -> extra input port "sub"; sub=1 computes a-b
//                  (b inverted, carry-in forced to 1, cin ignored).
//     undefined -> plain a+b+cin, no "sub" port.
module cla_nibble_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  // Reject widths the nibble datapath cannot handle at elaboration time.
  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
    $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // already the effective (possibly inverted) operand
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_nib_res;
  logic             w_ovf;

  // 4-bit carry-lookahead adder: generate/propagate per bit and fully
  // expanded carries, so every carry depends only on g, p and c0.
  // Returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Effective second operand and carry-in, captured only on the accept edge.
`ifdef CLA_SEQ_SUB_EN
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub | cin;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = cin;
`endif

  // Current nibble selection and lookahead slice.
  assign w_a_nib   = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib   = r_b[{r_idx, 2'b00} +: 4];
  assign w_nib_res = cla4(w_a_nib, w_b_nib, r_carry);
  assign w_last    = (r_idx == LAST_IDX);

  // Signed overflow: operands agree in sign but the result sign differs.
  // On the last nibble the result MSB is bit 3 of the slice output.
  assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_nib_res[3] != r_a[WIDTH-1]);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and input handshake; a DONE slot can be refilled in
  // the same cycle the result is taken, so back-to-back runs have no bubble.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          w_accept    = in_valid;
          w_state_nxt = in_valid ? S_RUN : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, nibble-serial accumulation and result/flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_a         <= a;
      r_b         <= w_b_eff;
      r_carry     <= w_cin_eff;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum[{r_idx, 2'b00} +: 4] <= w_nib_res[3:0];
      r_carry                    <= w_nib_res[4];
      if (w_last) begin
        r_idx       <= '0;
        r_cout      <= w_nib_res[4];
        r_ovf       <= w_ovf;
        r_out_valid <= 1'b1;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end else if (r_state == S_DONE && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Testbench for cla_nibble_sequencer (WIDTH=32): directed vector table,
// hand-written stall / back-to-back / mid-run reset sequences, and a
// randomised run against a behavioural a+b+cin model.
module tb_cla_nibble_sequencer;

  localparam int W = 32;
`ifdef CLA_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
`ifdef CLA_SEQ_SUB_EN
  logic         sub_i;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_pass  = 0;
  int n_total = 0;

  cla_nibble_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .cin       (cin_i),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present one operand pair at a falling edge; it is accepted on the next
  // rising edge. Operand inputs are then scrambled to prove they are not
  // re-sampled. Returns at the falling edge after the accept edge.
  task automatic start_txn(input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    in_valid = 1'b1;
    a_i      = a;
    b_i      = b;
    cin_i    = c;
    @(negedge clk);
    in_valid = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    cin_i    = 1'($urandom_range(0, 1));
  endtask

  // Count rising edges until out_valid is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Full transaction: accept, latency, result, stall with stability, release.
  task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [31:0] es, input logic ec,
                         input logic eo, input int stall, input bit chk_lat);
    int cyc;
    start_txn(a, b, c);
    wait_done(cyc);
    if (chk_lat) chk({name, " latency"}, 64'(cyc), 64'(8));
    chk({name, " result"}, 64'({out_valid, ovf, cout, sum}), 64'({1'b1, eo, ec, es}));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({name, " hold"}, 64'({in_ready, out_valid, ovf, cout, sum}),
          64'({1'b0, 1'b1, eo, ec, es}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (chk_lat) chk({name, " release"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        eovf;
    int          cyc;

    tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[2]  = '{32'h0000000F, 32'h00000000, 1'b1, 1'b0, 32'h00000010, 1'b0, 1'b0};
    tbl[3]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
    tbl[4]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[6]  = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[8]  = '{32'h89ABCDEF, 32'h01234567, 1'b0, 1'b0, 32'h8ACF1356, 1'b0, 1'b0};
    tbl[9]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[10] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = '0;
    b_i       = '0;
    cin_i     = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    sub_i     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset state", 64'({in_ready, out_valid, ovf, cout, sum}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].sub && !SUB_EN) continue;
`ifdef CLA_SEQ_SUB_EN
      sub_i = tbl[i].sub;
`endif
      run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
              tbl[i].sum, tbl[i].cout, tbl[i].ovf, 0, 1'b1);
    end
`ifdef CLA_SEQ_SUB_EN
    sub_i = 1'b0;
`endif

    // Stall in DONE for 5 cycles, then accept a new pair on the release edge.
    start_txn(32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_done(cyc);
    chk("stall latency", 64'(cyc), 64'(8));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall hold", 64'({in_ready, out_valid, ovf, cout, sum}),
          64'({1'b0, 1'b1, 1'b0, 1'b1, 32'h0}));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_i       = 32'h00000003;
    b_i       = 32'h00000004;
    cin_i     = 1'b0;
    #1;
    chk("b2b in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = 32'hDEADBEEF;
    b_i       = 32'h12345678;
    chk("b2b out_valid drop", 64'({out_valid, in_ready}), 64'({1'b0, 1'b0}));
    wait_done(cyc);
    chk("b2b latency", 64'(cyc), 64'(8));
    chk("b2b result", 64'({ovf, cout, sum}), 64'({1'b0, 1'b0, 32'h00000007}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Leave cout=1 behind, then reset during nibble 3 of the next run.
    run_txn("pre-reset", 32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b0);
    start_txn(32'h11111111, 32'h22222222, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid-run reset", 64'({out_valid, ovf, cout, sum}), 64'({1'b0, 1'b0, 1'b0, 32'h0}));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    run_txn("post-reset", 32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, 1'b0, 1, 1'b1);

    // Random operands with random result stalls against a behavioural model.
    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      m    = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      eovf = (ra[31] == rb[31]) && (m[31] != ra[31]);
      run_txn("random", ra, rb, rc, m[31:0], m[32], eovf, $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
